alu_seq: RTL and testbench
==========================

// Module: alu_seq
//
// PURPOSE
//   Parametrised, registered ALU for the MIPS datapath. It replaces the
//   2-bit-op combinational ALU with an 8-op unit behind a valid/ready handshake.
//   Single-cycle ops complete in 1 cycle. The optional multiply runs as a
//   WIDTH-cycle shift-add sequence. zero and a signed overflow flag are
//   registered together with result.
//
// PARAMETERS
//   WIDTH   32   operand/result width in bits; legal range >= 2
//
// PORTS
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous reset, active low
//   in_valid   in   1      operands and op present on a, b, alu_op
//   in_ready   out  1      block accepts an operation this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   alu_op     in   3      000 add, 001 sub, 010 and, 011 or,
//                          100 xor, 101 nor, 110 slt (signed), 111 mul
//   out_valid  out  1      result/zero/overflow hold a completed operation
//   out_ready  in   1      consumer takes the result this cycle
//   result     out  WIDTH  operation result
//   zero       out  1      result == 0
//   overflow   out  1      signed overflow; add and sub only, else 0
//
// BEHAVIOUR
// - Reset (async, reset_n=0): state=IDLE; out_valid=0; result=0; zero=0;
//   overflow=0; multiply counter and accumulator cleared. in_ready=1 after release.
// - FSM states IDLE, BUSY, DONE; BUSY exists only when ALU_MULT_EN is defined.
// - Accept: transfer occurs when in_valid && in_ready.
//   in_ready = (state==IDLE) || (state==DONE && out_ready).
// - Single-cycle op accepted: next state DONE. Outputs registered; latency 1 clk.
// - mul accepted: latch a and b. State BUSY for exactly WIDTH cycles, one
//   multiplier bit per cycle. Then DONE with the low WIDTH bits of a*b.
//   Latency WIDTH+1 clk.
// - DONE: result, zero and overflow hold stable while out_valid && !out_ready.
//   - out_ready=1 with no new accept: go to IDLE; out_valid=0; result keeps
//     its value.
//   - out_ready=1 with a simultaneous accept: load the new result directly.
//     out_valid stays 1, giving throughput of 1 op/clk for single-cycle ops.
//   - out_ready=1 with a simultaneous mul accept: go to BUSY; out_valid=0.
// - Arithmetic: add and sub wrap modulo 2^WIDTH.
// - add overflow = (a[MSB]==b[MSB]) && (res[MSB]!=a[MSB]).
// - sub overflow = (a[MSB]!=b[MSB]) && (res[MSB]!=a[MSB]).
// - slt returns {WIDTH-1 zeros, signed(a)<signed(b)}.
// - nor returns ~(a|b).
// - zero is computed from the registered result value.
// - in_valid is ignored while in BUSY, because in_ready=0 there.
// - An operation in flight is discarded on reset mid-op, with no partial result.
//
// CONFIGURATION
// - ALU_MULT_EN defined: op 111 is the WIDTH-cycle multiply; the BUSY state
//   and counter (clog2(WIDTH)+1 bits) are present.
// - ALU_MULT_EN undefined: op 111 completes in 1 cycle like the other ops,
//   with result=0, zero=1, overflow=0. No BUSY state; multiply logic is
//   absent. Timing for all other ops is unchanged.
//
// TESTING  (WIDTH=32 unless noted)
// - Reset: hold reset_n=0 mid-multiply -> out_valid=0, result=0, in_ready=1
//   after release; no stale output appears.
// - add a=1, b=3 -> next clk: out_valid=1, result=4, zero=0, overflow=0.
//   sub a=3, b=3 -> result=0, zero=1.
// - add a=32'h7FFF_FFFF, b=1 -> result=32'h8000_0000, overflow=1.
//   slt a=32'hFFFF_FFFF, b=0 -> result=1.
// - Back-to-back stream of 8 ops, out_ready=1 -> one result per clk, in order.
//   With out_ready=0 for 3 clks -> outputs hold and in_ready=0.
// - ALU_MULT_EN: mul a=7, b=6 -> in_ready=0 for 32 clks, then result=42;
//   mul a=32'hFFFF_FFFF, b=2 -> result=32'hFFFF_FFFE.
// - Without ALU_MULT_EN: op 111 -> 1 clk later result=0, zero=1.
//   WIDTH=8 build: add 8'hFF+1 -> result=0, zero=1, overflow=0.

Source files
------------

// File: rtl/alu_seq.sv
// Registered 8-op ALU behind a valid/ready handshake. Defining ALU_MULT_EN
// enables op 111 as a WIDTH-cycle shift-add multiply; otherwise it yields 0.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int MSB = WIDTH - 1;

  // Handshake: a transfer happens on any rising edge where valid && ready.
  // Inputs are taken when in_valid && in_ready; the result is consumed when
  // out_valid && out_ready. out_valid holds, with stable data, until consumed.
`ifdef ALU_MULT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t state, state_nxt;

  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign dbg_state = state;

`ifdef ALU_MULT_EN
  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             mul_last;

  assign is_mul   = (alu_op == 3'b111);
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == CW'(WIDTH - 1));
`else
  assign is_mul = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_res = a + b;
        alu_ovf = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      3'b001: begin
        alu_res = a - b;
        alu_ovf = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      3'b010: alu_res = a & b;
      3'b011: alu_res = a | b;
      3'b100: alu_res = a ^ b;
      3'b101: alu_res = ~(a | b);
      3'b110: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = is_mul ? state_t'(2'd1) : DONE;
      end
`ifdef ALU_MULT_EN
      BUSY: begin
        if (mul_last) state_nxt = DONE;
      end
`endif
      DONE: begin
        if (out_ready) begin
          if (accept) state_nxt = is_mul ? state_t'(2'd1) : DONE;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result flags are registered alongside result; they hold while DONE stalls
  // and keep their last value after the result is consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept && !is_mul) begin
      result   <= alu_res;
      zero     <= (alu_res == '0);
      overflow <= alu_ovf;
`ifdef ALU_MULT_EN
    end else if ((state == BUSY) && mul_last) begin
      result   <= acc_nxt;
      zero     <= (acc_nxt == '0);
      overflow <= 1'b0;
`endif
    end
  end

`ifdef ALU_MULT_EN
  // One multiplier bit per BUSY cycle: add shifted multiplicand when set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (accept && is_mul) begin
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (state == BUSY) begin
      cnt    <= cnt + CW'(1);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); the multiply checks
// follow whether ALU_MULT_EN is defined for the build.
module tb_alu_seq;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] exp_q[$];

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one op with out_ready low, wait for its result, check, then consume.
  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input logic [WIDTH-1:0] exp_r, input logic exp_z,
                       input logic exp_o, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, in_ready, 1);
    alu_op = op; a = va; b = vb; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      check({tag, "_busy_rdy"}, in_ready, 0);
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_res"}, result, exp_r);
    check({tag, "_zero"}, zero, exp_z);
    check({tag, "_ovf"}, overflow, exp_o);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle"}, out_valid, 0);
    check({tag, "_keep"}, result, exp_r);
  endtask

  logic [2:0]       s_op [8];
  logic [WIDTH-1:0] s_a  [8];
  logic [WIDTH-1:0] s_b  [8];
  logic [WIDTH-1:0] s_r  [8];

  initial begin
    s_op[0] = 3'b000; s_a[0] = 32'd10;        s_b[0] = 32'd20;        s_r[0] = 32'd30;
    s_op[1] = 3'b001; s_a[1] = 32'd5;         s_b[1] = 32'd7;         s_r[1] = 32'hFFFF_FFFE;
    s_op[2] = 3'b010; s_a[2] = 32'hF0F0_F0F0; s_b[2] = 32'hFF00_FF00; s_r[2] = 32'hF000_F000;
    s_op[3] = 3'b011; s_a[3] = 32'h0F0F_0000; s_b[3] = 32'h0000_00FF; s_r[3] = 32'h0F0F_00FF;
    s_op[4] = 3'b100; s_a[4] = 32'hAAAA_AAAA; s_b[4] = 32'hFFFF_FFFF; s_r[4] = 32'h5555_5555;
    s_op[5] = 3'b101; s_a[5] = 32'h0;         s_b[5] = 32'h0;         s_r[5] = 32'hFFFF_FFFF;
    s_op[6] = 3'b110; s_a[6] = 32'd5;         s_b[6] = 32'hFFFF_FFFB; s_r[6] = 32'd0;
    s_op[7] = 3'b000; s_a[7] = 32'hFFFF_FFFF; s_b[7] = 32'd1;         s_r[7] = 32'd0;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; alu_op = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_vld", out_valid, 0);
    check("rst_res", result, 0);
    check("rst_zero", zero, 0);
    check("rst_ovf", overflow, 0);
    check("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_rdy", in_ready, 1);
    check("rel_vld", out_valid, 0);

    do_op("add1", 3'b000, 32'd1, 32'd3, 32'd4, 1'b0, 1'b0, 0);
    do_op("sub0", 3'b001, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 0);
    do_op("addov", 3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 0);
    do_op("subov", 3'b001, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 0);
    do_op("slt1", 3'b110, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1'b0, 0);
    do_op("slt0", 3'b110, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 0);
    do_op("nor", 3'b101, 32'h0000_FFFF, 32'hFF00_0000, 32'h00FF_0000, 1'b0, 1'b0, 0);
`ifdef ALU_MULT_EN
    do_op("mul42", 3'b111, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, WIDTH);
    do_op("mulwrap", 3'b111, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, WIDTH);
`else
    do_op("mul_off", 3'b111, 32'd7, 32'd6, 32'd0, 1'b1, 1'b0, 0);
`endif

    // back-to-back stream, one result per clock, in order
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("strm_vld", out_valid, 1);
        check("strm_res", result, exp_q.pop_front());
      end
      check("strm_rdy", in_ready, 1);
      alu_op = s_op[i]; a = s_a[i]; b = s_b[i]; in_valid = 1'b1;
      exp_q.push_back(s_r[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("strm_vld", out_valid, 1);
    check("strm_res", result, exp_q.pop_front());
    check("strm_zero", zero, 1);
    check("strm_ovf", overflow, 0);
    @(negedge clk);
    check("strm_end", out_valid, 0);
    out_ready = 1'b0;

    // stall: outputs hold and in_ready drops while out_ready is low
    alu_op = 3'b000; a = 32'd100; b = 32'd23; in_valid = 1'b1;
    @(negedge clk);
    alu_op = 3'b001; a = 32'd50; b = 32'd8;
    for (int i = 0; i < 3; i++) begin
      check("stall_vld", out_valid, 1);
      check("stall_res", result, 32'd123);
      check("stall_rdy", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_rdy", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("unstall_vld", out_valid, 1);
    check("unstall_res", result, 32'd42);
    @(negedge clk);
    out_ready = 1'b0;
    check("unstall_idle", out_valid, 0);

    // reset with an operation in flight
    alu_op = 3'b111; a = 32'd9; b = 32'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mrst_vld", out_valid, 0);
    check("mrst_res", result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mrst_rdy", in_ready, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) check("mrst_stale", out_valid, 0);
    end
    check("mrst_vld_end", out_valid, 0);
    check("mrst_zero", zero, 0);

    do_op("post_rst", 3'b011, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
